// File: rtl/alu_pipe.sv
// Two-stage RMT action ALU for one PHV container: operand/opcode register (S1) feeding a result
// register (S2) with valid/ready backpressure and a sticky overflow/borrow flag.
module alu_pipe #(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    output logic                  action_ready,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid,
    input  logic                  container_out_ready,
    output logic                  ovf_flag,
    input  logic                  ovf_clr
);

    localparam int W = DATA_WIDTH;

    // Handshake: a transfer happens on any cycle where valid & ready are both high; the sender
    // holds its payload stable until then. action_ready looks straight through to
    // container_out_ready so a full pipe can still accept while the result drains.
    logic         s1_valid;
    logic [3:0]   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         adv;
    logic         s1_load;

    logic [3:0]   in_op;
    logic [W-1:0] in_imm;
    logic         in_use_imm;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] result;
    logic         ovf_set;

    logic         unused_bits;

    assign adv          = ~container_out_valid | container_out_ready;
    assign action_ready = ~s1_valid | adv;
    assign s1_load      = action_ready;

    assign in_op       = action_in[24:21];
    assign in_imm      = W'(action_in[15:0]);
    assign in_use_imm  = (in_op == 4'h3) || (in_op == 4'h4) || (in_op == 4'hF);
    assign unused_bits = ^{action_in, 1'(STAGE)};

    // The immediate replaces operand 2 at capture, so S2 only ever sees two operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 4'h0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= action_valid;
            if (action_valid) begin
                s1_op <= in_op;
                s1_a  <= operand_1_in;
                s1_b  <= in_use_imm ? in_imm : operand_2_in;
            end
        end
    end

    always_comb begin
        sum     = {1'b0, s1_a} + {1'b0, s1_b};
        diff    = {1'b0, s1_a} - {1'b0, s1_b};
        result  = s1_a;
        ovf_set = 1'b0;
        case (s1_op)
            4'h0, 4'h8: result = s1_a;
            4'h1, 4'h9, 4'h3: begin
                result  = sum[W-1:0];
                ovf_set = sum[W];
            end
            4'h2, 4'hA, 4'h4: begin
                result  = diff[W-1:0];
                ovf_set = diff[W];
            end
            4'h5: result = s1_a & s1_b;
            4'h6: result = s1_a | s1_b;
            4'h7: result = s1_a ^ s1_b;
            4'hB: result = sum[W] ? '1 : sum[W-1:0];
            4'hC: result = diff[W] ? '0 : diff[W-1:0];
            4'hD: result = (s1_a > s1_b) ? s1_a : s1_b;
            4'hE: result = (s1_a < s1_b) ? s1_a : s1_b;
            4'hF: result = s1_b;
            default: result = s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            container_out_valid <= 1'b0;
            container_out       <= '0;
        end else if (adv) begin
            container_out_valid <= s1_valid;
            if (s1_valid) begin
                container_out <= result;
            end
        end
    end

    // A set arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (adv && s1_valid && ovf_set) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic scored against a
// behavioural model; a second 16-bit instance repeats the basic opcode checks.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic [24:0] action_in;
    logic        action_valid;
    logic        action_ready;
    logic [47:0] operand_1_in;
    logic [47:0] operand_2_in;
    logic [47:0] container_out;
    logic        container_out_valid;
    logic        container_out_ready;
    logic        ovf_flag;
    logic        ovf_clr;

    logic [24:0] action_in16;
    logic        action_valid16;
    logic        action_ready16;
    logic [15:0] op1_16;
    logic [15:0] op2_16;
    logic [15:0] out16;
    logic        out_valid16;
    logic        out_ready16;
    logic        ovf16;
    logic        ovf_clr16;

    int n_vec = 0;
    int n_err = 0;
    logic [47:0] exp_q[$];

    alu_pipe #(.STAGE(0), .ACTION_LEN(25), .DATA_WIDTH(48)) dut (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .action_ready(action_ready), .operand_1_in(operand_1_in), .operand_2_in(operand_2_in),
        .container_out(container_out), .container_out_valid(container_out_valid),
        .container_out_ready(container_out_ready), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    alu_pipe #(.STAGE(1), .ACTION_LEN(25), .DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .action_in(action_in16), .action_valid(action_valid16),
        .action_ready(action_ready16), .operand_1_in(op1_16), .operand_2_in(op2_16),
        .container_out(out16), .container_out_valid(out_valid16),
        .container_out_ready(out_ready16), .ovf_flag(ovf16), .ovf_clr(ovf_clr16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint unsigned ref_result(input int op, input longint unsigned a,
            input longint unsigned b, input longint unsigned imm, input int w);
        longint unsigned mask, x, y, r;
        mask = (64'd1 << w) - 1;
        x = a & mask;
        y = (op == 3 || op == 4 || op == 15) ? (imm & 64'hFFFF) : (b & mask);
        case (op)
            1, 9, 3:   r = (x + y) & mask;
            2, 10, 4:  r = (x - y) & mask;
            5:         r = x & y;
            6:         r = x | y;
            7:         r = x ^ y;
            11:        r = (x + y > mask) ? mask : x + y;
            12:        r = (x < y) ? 0 : x - y;
            13:        r = (x > y) ? x : y;
            14:        r = (x < y) ? x : y;
            15:        r = y;
            default:   r = x;
        endcase
        return r;
    endfunction

    function automatic bit ref_ovf(input int op, input longint unsigned a,
            input longint unsigned b, input longint unsigned imm, input int w);
        longint unsigned mask, x, y;
        mask = (64'd1 << w) - 1;
        x = a & mask;
        y = (op == 3 || op == 4) ? (imm & 64'hFFFF) : (b & mask);
        if (op == 1 || op == 9 || op == 3) return (x + y) > mask;
        if (op == 2 || op == 10 || op == 4) return x < y;
        return 1'b0;
    endfunction

    function automatic logic [47:0] rand48();
        case ($urandom_range(0, 3))
            0: return 48'hFFFF_FFFF_FFFF;
            1: return 48'($urandom_range(0, 15));
            default: return {16'($urandom), 32'($urandom)};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && container_out_valid && container_out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h, expected no result", container_out);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if (container_out !== e) begin
                    n_err++;
                    $display("FAIL result: got %h, expected %h", container_out, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called aligned to #1 after a rising edge; returns aligned the same way.
    task automatic send(input int op, input logic [47:0] a, input logic [47:0] b,
                        input logic [15:0] imm);
        bit acc;
        acc = 1'b0;
        action_in    = {4'(op), 5'b0, imm};
        operand_1_in = a;
        operand_2_in = b;
        action_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (action_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        action_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: action_ready stayed %b, expected 1", action_ready);
        end else begin
            exp_q.push_back(48'(ref_result(op, a, b, imm, 48)));
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (container_out_valid !== 1'b0 || container_out !== 48'h0 || ovf_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b out=%h ovf=%b, expected 0 0 0",
                     container_out_valid, container_out, ovf_flag);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (action_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b, expected 1", action_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_latency();
        bit ok;
        send(1, 48'h5, 48'h3, 16'h0);
        @(negedge clk);
        n_vec++;
        if (container_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: valid=%b one cycle after accept, expected 0",
                     container_out_valid);
        end
        @(negedge clk);
        n_vec++;
        if (container_out_valid !== 1'b1 || container_out !== 48'h8 || ovf_flag !== 1'b0) begin
            n_err++;
            $display("FAIL latency_add: valid=%b out=%h ovf=%b, expected 1 000000000008 0",
                     container_out_valid, container_out, ovf_flag);
        end
        drain(ok);
    endtask

    task automatic test_ovf();
        bit ok;
        pulse_clr();
        send(2, 48'h1, 48'h2, 16'h0);
        drain(ok);
        @(negedge clk);
        n_vec++;
        if (ovf_flag !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_borrow: got %b, expected 1", ovf_flag);
        end
        @(posedge clk);
        #1;
        pulse_clr();
        @(negedge clk);
        n_vec++;
        if (ovf_flag !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b, expected 0", ovf_flag);
        end
        @(posedge clk);
        #1;
        // Clear is asserted exactly on the edge where the borrowing sub moves into S2.
        send(2, 48'h1, 48'h2, 16'h0);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovf_flag !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: got %b, expected 1", ovf_flag);
        end
        @(posedge clk);
        #1;
        drain(ok);
    endtask

    task automatic test_saturate();
        bit ok;
        pulse_clr();
        send(11, 48'hFFFF_FFFF_FFF0, 48'h20, 16'h0);
        send(12, 48'h5, 48'h9, 16'h0);
        drain(ok);
        @(negedge clk);
        n_vec++;
        if (!ok || ovf_flag !== 1'b0) begin
            n_err++;
            $display("FAIL sat_no_ovf: drained=%b ovf=%b, expected 1 0", ok, ovf_flag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm_minmax();
        bit ok;
        send(3, 48'h10, 48'hFFFF, 16'h1234);
        send(15, 48'h77, 48'h55, 16'hBEEF);
        send(13, 48'h7, 48'h9, 16'h0);
        send(14, 48'h7, 48'h9, 16'h0);
        send(5, 48'hF0F0_0000_FF00, 48'hFF00_FF00_0F0F, 16'h0);
        send(6, 48'hF0F0_0000_FF00, 48'h0F00_00FF_000F, 16'h0);
        send(7, 48'hAAAA_5555_FFFF, 48'hFFFF_FFFF_0000, 16'h0);
        send(4, 48'h100, 48'h0, 16'h0101);
        send(8, 48'h1234_5678_9ABC, 48'h0, 16'h0);
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL imm_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [47:0] held;
        container_out_ready = 1'b0;
        send(0, 48'd1, 48'h0, 16'h0);
        send(0, 48'd2, 48'h0, 16'h0);
        @(negedge clk);
        n_vec++;
        if (action_ready !== 1'b0 || container_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_ready: ready=%b valid=%b, expected 0 1",
                     action_ready, container_out_valid);
        end
        held = container_out;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (container_out !== held || container_out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold: out=%h valid=%b, expected %h 1",
                         container_out, container_out_valid, held);
            end
        end
        @(posedge clk);
        #1;
        container_out_ready = 1'b1;
        for (int i = 3; i <= 8; i++) send(0, 48'(i), 48'h0, 16'h0);
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send($urandom_range(0, 15), rand48(), rand48(), 16'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    container_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        container_out_ready = 1'b1;
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL random_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        container_out_ready = 1'b0;
        send(2, 48'h0, 48'h1, 16'h0);
        send(1, 48'h2, 48'h3, 16'h0);
        @(negedge clk);
        n_vec++;
        if (ovf_flag !== 1'b1 || container_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: ovf=%b valid=%b, expected 1 1", ovf_flag, container_out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (container_out_valid !== 1'b0 || container_out !== 48'h0 || ovf_flag !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b out=%h ovf=%b, expected 0 0 0",
                     container_out_valid, container_out, ovf_flag);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        container_out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (container_out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL flushed_ops: %0d results after release, expected 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_width16();
        int              ops[8] = '{1, 2, 11, 12, 3, 15, 13, 14};
        longint unsigned as[8]  = '{64'h5, 64'h1, 64'hFFF0, 64'h5, 64'h10, 64'h0, 64'h7, 64'h7};
        longint unsigned bs[8]  = '{64'h3, 64'h2, 64'h20, 64'h9, 64'h0, 64'h0, 64'h9, 64'h9};
        longint unsigned ims[8] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h1234, 64'hBEEF, 64'h0, 64'h0};
        logic [15:0] e;
        logic        eo;
        out_ready16 = 1'b1;
        ovf_clr16   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e  = 16'(ref_result(ops[i], as[i], bs[i], ims[i], 16));
            eo = ref_ovf(ops[i], as[i], bs[i], ims[i], 16);
            action_in16    = {4'(ops[i]), 5'b0, 16'(ims[i])};
            op1_16         = 16'(as[i]);
            op2_16         = 16'(bs[i]);
            action_valid16 = 1'b1;
            @(negedge clk);
            n_vec++;
            if (action_ready16 !== 1'b1) begin
                n_err++;
                $display("FAIL w16_ready[%0d]: got %b, expected 1", i, action_ready16);
            end
            @(posedge clk);
            #1;
            action_valid16 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            n_vec++;
            if (out_valid16 !== 1'b1 || out16 !== e || ovf16 !== eo) begin
                n_err++;
                $display("FAIL w16_op[%0d]: valid=%b out=%h ovf=%b, expected 1 %h %b",
                         i, out_valid16, out16, ovf16, e, eo);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        action_in = '0; action_valid = 1'b0; operand_1_in = '0; operand_2_in = '0;
        container_out_ready = 1'b1; ovf_clr = 1'b0;
        action_in16 = '0; action_valid16 = 1'b0; op1_16 = '0; op2_16 = '0;
        out_ready16 = 1'b1; ovf_clr16 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_latency();
        test_ovf();
        test_saturate();
        test_imm_minmax();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        test_width16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
